// File: rtl/alu_seq_pkg.sv
// Shared types and ALU opcode constants for the byte-serial ALU sequencer.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [3:0] ADD_S = 4'b1001;
   localparam logic       ADD_M = 1'b0;
   localparam logic [3:0] SUB_S = 4'b0110;
   localparam logic       SUB_M = 1'b0;
   localparam logic [3:0] XOR_S = 4'b0110;
   localparam logic       XOR_M = 1'b1;
   localparam logic [3:0] AND_S = 4'b1011;
   localparam logic       AND_M = 1'b1;

   localparam logic CARRY_NONE = 1'b1;

endpackage

// File: rtl/alu_byte_mux.sv
// Picks byte[idx] out of the latched A/B operand vectors.
module alu_byte_mux #(
   parameter int NUM_BYTES = 4,
   parameter int IDX_W     = 3
) (
   input  logic [NUM_BYTES*8-1:0] a_vec,
   input  logic [NUM_BYTES*8-1:0] b_vec,
   input  logic [IDX_W-1:0]       idx,
   output logic [7:0]             a_byte,
   output logic [7:0]             b_byte
);

   assign a_byte = a_vec[8*int'(idx) +: 8];
   assign b_byte = b_vec[8*int'(idx) +: 8];

endmodule

// File: rtl/alu_chain_sequencer.sv
// Runs a multi-byte op through one 8-bit ALU, LSB first, with the
// carry out of each byte registered into the next.
module alu_chain_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_BYTES = 4,
   parameter int LEN_W     = $clog2(NUM_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   start,
   input  logic                   abort,
   input  logic [LEN_W-1:0]       len,
   input  logic [3:0]             s,
   input  logic                   m,
   input  logic                   cn_in,
   input  logic [NUM_BYTES*8-1:0] a_vec,
   input  logic [NUM_BYTES*8-1:0] b_vec,
   output logic [7:0]             alu_a,
   output logic [7:0]             alu_b,
   output logic [3:0]             alu_s,
   output logic                   alu_m,
   output logic                   alu_cn,
   input  logic [7:0]             alu_f,
   input  logic                   alu_cn4,
   input  logic                   alu_equal,
   output logic [NUM_BYTES*8-1:0] f_vec,
   output logic                   cn_out,
   output logic                   equal_all,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   aborted
);

   localparam int VW = NUM_BYTES * 8;

   state_t           state;
   state_t           state_nx;
   logic [VW-1:0]    a_lat;
   logic [VW-1:0]    b_lat;
   logic [3:0]       s_lat;
   logic             m_lat;
   logic [LEN_W-1:0] len_lat;
   logic [LEN_W-1:0] idx;
   logic             carry;
   logic             len_ok;
   logic             last;
   logic [7:0]       mux_a;
   logic [7:0]       mux_b;

   assign len_ok = (len != '0) && (int'(len) <= NUM_BYTES);
   assign last   = (idx == len_lat - LEN_W'(1));

   alu_byte_mux #(
      .NUM_BYTES (NUM_BYTES),
      .IDX_W     (LEN_W)
   ) u_mux (
      .a_vec  (a_lat),
      .b_vec  (b_lat),
      .idx    (idx),
      .a_byte (mux_a),
      .b_byte (mux_b)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start && len_ok) state_nx = RUN;
         RUN: begin
            if (abort)     state_nx = IDLE;
            else if (last) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)      state <= IDLE;
      else if (ena) state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_lat     <= '0;
         b_lat     <= '0;
         s_lat     <= '0;
         m_lat     <= 1'b0;
         len_lat   <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         f_vec     <= '0;
         cn_out    <= 1'b1;
         equal_all <= 1'b0;
         err       <= 1'b0;
         aborted   <= 1'b0;
      end else if (ena) begin
         err     <= 1'b0;
         aborted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && len_ok) begin
                  a_lat     <= a_vec;
                  b_lat     <= b_vec;
                  s_lat     <= s;
                  m_lat     <= m;
                  len_lat   <= len;
                  carry     <= cn_in;
                  f_vec     <= '0;
                  equal_all <= 1'b1;
                  idx       <= '0;
               end else if (start) begin
                  err <= 1'b1;
               end
            end
            RUN: begin
               // abort drops the byte in flight, including the last one
               if (abort) begin
                  aborted <= 1'b1;
               end else begin
                  f_vec[8*int'(idx) +: 8] <= alu_f;
                  carry     <= alu_cn4;
                  equal_all <= equal_all & alu_equal;
                  idx       <= idx + LEN_W'(1);
                  if (last) cn_out <= alu_cn4;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_a  = (state == RUN) ? mux_a : 8'h00;
   assign alu_b  = (state == RUN) ? mux_b : 8'h00;
   assign alu_cn = (state == RUN) ? carry : CARRY_NONE;
   assign alu_s  = s_lat;
   assign alu_m  = m_lat;
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

endmodule

// File: tb/tb_alu_chain_sequencer.sv
// Directed bench for alu_chain_sequencer with a behavioural 8-bit 74181
// pair (active-high data, active-low carry) closing the ALU loop.
module tb_alu_chain_sequencer;
   import alu_seq_pkg::*;

   localparam int NB = 4;
   localparam int LW = $clog2(NB + 1);
   localparam int VW = NB * 8;

   logic          clk = 1'b0;
   logic          rst, ena, start, abort;
   logic [LW-1:0] len;
   logic [3:0]    s;
   logic          m, cn_in;
   logic [VW-1:0] a_vec, b_vec;
   logic [7:0]    alu_a, alu_b, alu_f;
   logic [3:0]    alu_s;
   logic          alu_m, alu_cn, alu_cn4, alu_equal;
   logic [VW-1:0] f_vec;
   logic          cn_out, equal_all, busy, done, err, aborted;
   logic [8:0]    sum;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_chain_sequencer #(.NUM_BYTES(NB)) dut (
      .clk(clk), .rst(rst), .ena(ena), .start(start),
      .abort(abort), .len(len), .s(s), .m(m), .cn_in(cn_in),
      .a_vec(a_vec), .b_vec(b_vec),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_m(alu_m), .alu_cn(alu_cn), .alu_f(alu_f),
      .alu_cn4(alu_cn4), .alu_equal(alu_equal),
      .f_vec(f_vec), .cn_out(cn_out), .equal_all(equal_all),
      .busy(busy), .done(done), .err(err), .aborted(aborted)
   );

   // 74181: SUB is A-B-1 with cn=1; A=B output is F all ones
   always_comb begin
      sum     = '0;
      alu_f   = 8'h00;
      alu_cn4 = 1'b1;
      if (!alu_m) begin
         if (alu_s == ADD_S)
            sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, ~alu_cn};
         else if (alu_s == SUB_S)
            sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, ~alu_cn};
         alu_f   = sum[7:0];
         alu_cn4 = ~sum[8];
      end else if (alu_s == XOR_S) begin
         alu_f = alu_a ^ alu_b;
      end else if (alu_s == AND_S) begin
         alu_f = alu_a & alu_b;
      end
      alu_equal = &alu_f;
   end

   typedef struct {
      logic [3:0]    s;
      logic          m;
      logic          cn;
      logic [LW-1:0] len;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      logic [VW-1:0] f;
      logic          c;
      logic          eq;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int busy_n;
      int done_cyc;
      string t;
      t = $sformatf("v%0d", k);
      s = v.s; m = v.m; cn_in = v.cn; len = v.len;
      a_vec = v.a; b_vec = v.b; start = 1'b1;
      tick();
      start = 1'b0;
      a_vec = ~v.a; b_vec = ~v.b; s = ~v.s; m = ~v.m; cn_in = ~v.cn;
      busy_n = 0;
      done_cyc = 0;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
         if (busy) busy_n++;
         if (done) done_cyc = c;
         tick();
      end
      chk({t, "_done_cyc"}, 64'(done_cyc), 64'(int'(v.len) + 1));
      chk({t, "_busy_n"}, 64'(busy_n), 64'(int'(v.len) + 1));
      chk({t, "_f_vec"}, 64'(f_vec), 64'(v.f));
      chk({t, "_cn_out"}, 64'(cn_out), 64'(v.c));
      chk({t, "_equal_all"}, 64'(equal_all), 64'(v.eq));
   endtask

   initial begin
      int done_cyc;
      vec_t v2;

      vecs[0] = '{ADD_S, ADD_M, 1'b1, 3'd4, 32'h000000FF,
                  32'h00000001, 32'h00000100, 1'b1, 1'b0};
      vecs[1] = '{ADD_S, ADD_M, 1'b1, 3'd4, 32'hFFFFFFFF,
                  32'h00000001, 32'h00000000, 1'b0, 1'b0};
      vecs[2] = '{SUB_S, SUB_M, 1'b1, 3'd2, 32'h00001234,
                  32'h00001234, 32'h0000FFFF, 1'b1, 1'b1};
      vecs[3] = '{SUB_S, SUB_M, 1'b1, 3'd2, 32'h00001234,
                  32'h00001235, 32'h0000FFFE, 1'b1, 1'b0};
      vecs[4] = '{XOR_S, XOR_M, 1'b1, 3'd3, 32'h00A5C3F0,
                  32'h005A3C0F, 32'h00FFFFFF, 1'b1, 1'b1};
      vecs[5] = '{AND_S, AND_M, 1'b1, 3'd1, 32'hDEADBEF0,
                  32'hFFFFFF3C, 32'h00000030, 1'b1, 1'b0};
      vecs[6] = '{ADD_S, ADD_M, 1'b0, 3'd4, 32'h7FFFFFFF,
                  32'h00000000, 32'h80000000, 1'b1, 1'b0};
      vecs[7] = '{ADD_S, ADD_M, 1'b1, 3'd4, 32'hFFFFFFFF,
                  32'h00000002, 32'h00000001, 1'b0, 1'b0};

      rst = 1'b1; ena = 1'b1; start = 1'b0; abort = 1'b0;
      len = '0; s = '0; m = 1'b0; cn_in = 1'b1;
      a_vec = '0; b_vec = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_f_vec", 64'(f_vec), 64'h0);
      chk("rst_cn_out", 64'(cn_out), 64'h1);
      chk("rst_equal_all", 64'(equal_all), 64'h0);
      chk("rst_flags", 64'({busy, done, err, aborted}), 64'h0);
      chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'h0);
      chk("rst_alu_sm", 64'({alu_s, alu_m}), 64'h0);
      chk("rst_alu_cn", 64'(alu_cn), 64'h1);

      for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

      // rejected lengths: err pulse, nothing else moves
      for (int k = 0; k < 2; k++) begin
         len = (k == 0) ? 3'd0 : 3'd5;
         a_vec = 32'h55555555; start = 1'b1;
         tick();
         start = 1'b0;
         chk($sformatf("err%0d_pulse", k), 64'(err), 64'h1);
         chk($sformatf("err%0d_busy", k), 64'(busy), 64'h0);
         tick();
         chk($sformatf("err%0d_clear", k), 64'(err), 64'h0);
         chk($sformatf("err%0d_f_vec", k), 64'(f_vec), 64'h1);
         chk($sformatf("err%0d_cn_out", k), 64'(cn_out), 64'h0);
      end

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", 64'({aborted, busy}), 64'h0);

      // abort in the 2nd RUN cycle: only byte 0 lands
      s = ADD_S; m = ADD_M; cn_in = 1'b1; len = 3'd4;
      a_vec = 32'h01020304; b_vec = 32'h10101010; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      chk("abort_pre_busy", 64'(busy), 64'h1);
      tick();
      abort = 1'b0;
      chk("abort_pulse", 64'(aborted), 64'h1);
      chk("abort_busy_done", 64'({busy, done}), 64'h0);
      chk("abort_f_vec", 64'(f_vec), 64'h00000014);
      chk("abort_cn_out", 64'(cn_out), 64'h0);
      tick();
      chk("abort_clear", 64'(aborted), 64'h0);
      v2 = '{ADD_S, ADD_M, 1'b1, 3'd2, 32'h000000FF,
             32'h00000001, 32'h00000100, 1'b1, 1'b0};
      run_vec(8, v2);

      // restart during RUN ignored; ena low 3 cycles delays done by 3
      s = ADD_S; m = ADD_M; cn_in = 1'b1; len = 3'd4;
      a_vec = 32'h000000FF; b_vec = 32'h00000001; start = 1'b1;
      tick();
      len = 3'd1; a_vec = 32'h0;
      tick();
      start = 1'b0;
      chk("restart_err", 64'(err), 64'h0);
      ena = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         chk($sformatf("freeze_c%0d", c), 64'({busy, done}), 64'h2);
         tick();
      end
      ena = 1'b1;
      done_cyc = 0;
      for (int c = 5; c <= 40 && done_cyc == 0; c++) begin
         if (done) done_cyc = c;
         else if (err) chk("restart_err_late", 64'(err), 64'h0);
         tick();
      end
      chk("freeze_done_cyc", 64'(done_cyc), 64'd8);
      chk("freeze_f_vec", 64'(f_vec), 64'h00000100);
      chk("freeze_cn_out", 64'(cn_out), 64'h1);

      // reset in the middle of a run
      len = 3'd4; a_vec = 32'hFFFFFFFF; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mid_busy", 64'(alu_cn), 64'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_f_vec", 64'(f_vec), 64'h0);
      chk("mrst_cn_eq", 64'({cn_out, equal_all}), 64'h2);
      chk("mrst_flags", 64'({busy, done, err, aborted}), 64'h0);
      chk("mrst_alu", 64'({alu_a, alu_b, alu_s, alu_m, alu_cn}),
          64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
